// File: rtl/eth_tx_pkt_gen_pkg.sv
// Shared types and helpers for the Ethernet TX frame generator.
// ETH_PKT_GEN_PRBS_EN selects PRBS31 payload instead of the incrementing pattern.
package eth_tx_pkt_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        PAY,
        IPG
    } state_t;

    localparam int unsigned MIN_LEN_DEF   = 64;
    localparam int unsigned MAX_LEN_DEF   = 9600;
    localparam logic [15:0] ETHERTYPE_DEF = 16'h88B5;

    typedef struct packed {
        logic [30:0] state;
        logic [63:0] data;
    } prbs_step_t;

    function automatic logic [7:0] last_keep(input logic [2:0] rem);
        logic [7:0] k;
        k = (rem == 3'd0) ? 8'hFF : 8'((9'd1 << rem) - 9'd1);
        return k;
    endfunction

    // Header fields are built MSB-first; lane 0 of tdata is sent first.
    function automatic logic [63:0] bswap64(input logic [63:0] be);
        logic [63:0] le;
        le = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            le[8*j +: 8] = be[8*(7-j) +: 8];
        end
        return le;
    endfunction

    // x^31 + x^28 + 1; output bit i of the word is the i-th generated bit.
    function automatic prbs_step_t prbs31_step64(input logic [30:0] s);
        prbs_step_t r;
        logic [30:0] x;
        logic        nb;
        x      = s;
        r.data = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            nb        = x[30] ^ x[27];
            x         = {x[29:0], nb};
            r.data[i] = nb;
        end
        r.state = x;
        return r;
    endfunction

endpackage

// File: rtl/eth_tx_pkt_gen_payload.sv
// Payload word source: incrementing bytes by default, PRBS31 when
// ETH_PKT_GEN_PRBS_EN is defined.
module eth_tx_pkt_gen_payload
    import eth_tx_pkt_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_i,
    input  logic        advance_i,
    input  logic [30:0] seed_i,
    output logic [63:0] word_o
);

`ifdef ETH_PKT_GEN_PRBS_EN
    logic [30:0] lfsr_q, lfsr_d;
    prbs_step_t  step;

    always_comb begin
        step   = prbs31_step64(lfsr_q);
        lfsr_d = lfsr_q;
        if (init_i) begin
            lfsr_d = seed_i;
        end else if (advance_i) begin
            lfsr_d = step.state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign word_o = step.data;
`else
    logic [7:0] base_q, base_d;
    logic       unused_seed;

    assign unused_seed = ^seed_i[30:8];

    always_comb begin
        base_d = base_q;
        if (init_i) begin
            base_d = seed_i[7:0];
        end else if (advance_i) begin
            base_d = base_q + 8'd8;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    always_comb begin
        word_o = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            word_o[8*j +: 8] = base_q + 8'(j);
        end
    end
`endif

endmodule

// File: rtl/eth_tx_pkt_gen.sv
// Per-channel AXI-ST Ethernet TX frame generator (fixed length, seq number, payload).
// Define ETH_PKT_GEN_PRBS_EN for PRBS31 payload.
module eth_tx_pkt_gen
    import eth_tx_pkt_gen_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MIN_LEN   = MIN_LEN_DEF,
    parameter int unsigned MAX_LEN   = MAX_LEN_DEF,
    parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_stop,
    input  logic [13:0]         cfg_pkt_len,
    input  logic [31:0]         cfg_num_pkts,
    input  logic [7:0]          cfg_ipg,
    input  logic [47:0]         cfg_dst_mac,
    input  logic [47:0]         cfg_src_mac,
    output logic                tx_tvalid,
    input  logic                tx_tready,
    output logic [DATA_W-1:0]   tx_tdata,
    output logic [DATA_W/8-1:0] tx_tkeep,
    output logic                tx_tlast,
    output logic                busy,
    output logic                done,
    output logic [31:0]         pkt_cnt,
    output logic [47:0]         byte_cnt
);

    localparam logic [13:0] MIN_L = 14'(MIN_LEN);
    localparam logic [13:0] MAX_L = 14'(MAX_LEN);

    state_t      state_q, state_d;
    logic [13:0] len_q, len_d;
    logic [31:0] num_q, num_d;
    logic [7:0]  ipg_q, ipg_d, gap_q, gap_d;
    logic [47:0] dst_q, dst_d, src_q, src_d;
    logic [15:0] seq_q, seq_d;
    logic [10:0] beat_q, beat_d;
    logic [31:0] pkt_q, pkt_d;
    logic [47:0] bytes_q, bytes_d;
    logic        stop_q, stop_d, done_q, done_d;

    logic [13:0] len_clamp;
    logic [10:0] nbeats;
    logic        is_last, fire, end_run;
    logic        pay_init, pay_adv;
    logic [30:0] pay_seed;
    logic [63:0] pay_word;

    assign len_clamp = (cfg_pkt_len < MIN_L) ? MIN_L :
                       (cfg_pkt_len > MAX_L) ? MAX_L : cfg_pkt_len;
    assign nbeats    = 11'((len_q + 14'd7) >> 3);
    assign tx_tvalid = state_q inside {HDR0, HDR1, PAY};
    assign is_last   = (state_q == PAY) && (beat_q == nbeats - 11'd1);
    assign fire      = tx_tvalid && tx_tready;
    assign end_run   = ((num_q != '0) && (pkt_q + 32'd1 == num_q)) || stop_q || cfg_stop;

`ifdef ETH_PKT_GEN_PRBS_EN
    assign pay_init = (state_q == IDLE) && cfg_start;
    assign pay_seed = 31'h7FFF_FFFF;
`else
    // Reloaded every header beat so each frame starts from its own seq.
    assign pay_init = (state_q == HDR0) || (state_q == HDR1);
    assign pay_seed = {23'd0, seq_q[7:0]};
`endif
    assign pay_adv  = (state_q == PAY) && fire;

    eth_tx_pkt_gen_payload u_payload (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_i    (pay_init),
        .advance_i (pay_adv),
        .seed_i    (pay_seed),
        .word_o    (pay_word)
    );

    always_comb begin
        tx_tdata = '0;
        tx_tkeep = '0;
        tx_tlast = 1'b0;
        unique case (state_q)
            HDR0: begin
                tx_tdata = bswap64({dst_q, src_q[47:32]});
                tx_tkeep = '1;
            end
            HDR1: begin
                tx_tdata = bswap64({src_q[31:0], ETHERTYPE, seq_q});
                tx_tkeep = '1;
            end
            PAY: begin
                tx_tdata = pay_word;
                tx_tkeep = is_last ? last_keep(len_q[2:0]) : '1;
                tx_tlast = is_last;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        num_d   = num_q;
        ipg_d   = ipg_q;
        gap_d   = gap_q;
        dst_d   = dst_q;
        src_d   = src_q;
        seq_d   = seq_q;
        beat_d  = beat_q;
        pkt_d   = pkt_q;
        bytes_d = bytes_q;
        stop_d  = stop_q;
        done_d  = 1'b0;

        if (cfg_stop && (state_q != IDLE)) begin
            stop_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    len_d   = len_clamp;
                    num_d   = cfg_num_pkts;
                    ipg_d   = cfg_ipg;
                    dst_d   = cfg_dst_mac;
                    src_d   = cfg_src_mac;
                    seq_d   = '0;
                    beat_d  = '0;
                    pkt_d   = '0;
                    bytes_d = '0;
                    stop_d  = 1'b0;
                    state_d = HDR0;
                end
            end
            HDR0, HDR1: begin
                if (fire) begin
                    beat_d  = beat_q + 11'd1;
                    state_d = (state_q == HDR0) ? HDR1 : PAY;
                end
            end
            PAY: begin
                if (fire && is_last) begin
                    pkt_d   = pkt_q + 32'd1;
                    bytes_d = bytes_q + 48'(len_q);
                    seq_d   = seq_q + 16'd1;
                    beat_d  = '0;
                    if (end_run) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (ipg_q == '0) begin
                        state_d = HDR0;
                    end else begin
                        gap_d   = ipg_q - 8'd1;
                        state_d = IPG;
                    end
                end else if (fire) begin
                    beat_d = beat_q + 11'd1;
                end
            end
            IPG: begin
                if (cfg_stop || stop_q) begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gap_q == '0) begin
                    state_d = HDR0;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            num_q   <= '0;
            ipg_q   <= '0;
            gap_q   <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            seq_q   <= '0;
            beat_q  <= '0;
            pkt_q   <= '0;
            bytes_q <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            num_q   <= num_d;
            ipg_q   <= ipg_d;
            gap_q   <= gap_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            seq_q   <= seq_d;
            beat_q  <= beat_d;
            pkt_q   <= pkt_d;
            bytes_q <= bytes_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign pkt_cnt  = pkt_q;
    assign byte_cnt = bytes_q;

endmodule

// File: tb/tb_eth_tx_pkt_gen.sv
// Self-checking bench for eth_tx_pkt_gen: byte-level frame model plus directed tests.
`timescale 1ns/1ps
module tb_eth_tx_pkt_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0;
    logic [13:0] cfg_pkt_len = '0;
    logic [31:0] cfg_num_pkts = '0;
    logic [7:0]  cfg_ipg = '0;
    logic [47:0] cfg_dst_mac = 48'h0011_2233_4455;
    logic [47:0] cfg_src_mac = 48'h6677_8899_AABB;
    logic        tx_tvalid, tx_tready, tx_tlast, busy, done;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tkeep;
    logic [31:0] pkt_cnt;
    logic [47:0] byte_cnt;

    eth_tx_pkt_gen dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_pkt_len(cfg_pkt_len), .cfg_num_pkts(cfg_num_pkts), .cfg_ipg(cfg_ipg),
        .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
        .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .busy(busy), .done(done),
        .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of the frame being transmitted, tracked in bytes.
    int          m_len = 64;
    logic [7:0]  m_ipg = '0;
    logic [47:0] m_dst, m_src;
    logic [15:0] m_seq = '0;
    logic [15:0] m_et = 16'h88B5;
    logic [30:0] prbs_s = '1;
    int          m_idx = 0, beats = 0, last_beats = 0, frames = 0;
    int          gap_cnt = 0, last_gap = -1, rem = 0;
    bit          in_frame = 0, gap_armed = 0, stall_prev = 0, bp_en = 0;
    logic [7:0]  last_keep_seen;
    logic [63:0] cap [0:2];
    logic [15:0] seq_log [0:7];
    logic [63:0] hold_data, e_data, e_mask;
    logic [7:0]  hold_keep, e_keep;
    logic        hold_last, e_last;

    function automatic int clampl(input int l);
        return (l < 64) ? 64 : ((l > 9600) ? 9600 : l);
    endfunction

    function automatic logic [7:0] hdr_byte(input int i);
        if (i < 6)       return m_dst[8*(5-i) +: 8];
        else if (i < 12) return m_src[8*(11-i) +: 8];
        else if (i < 14) return m_et[8*(13-i) +: 8];
        else             return m_seq[8*(15-i) +: 8];
    endfunction

    function automatic logic [7:0] prbs_byte();
        logic [7:0] b;
        logic       nb;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            nb     = prbs_s[30] ^ prbs_s[27];
            prbs_s = {prbs_s[29:0], nb};
            b[k]   = nb;
        end
        return b;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0; gap_armed = 0; stall_prev = 0; m_idx = 0; beats = 0;
        end else begin
            if (stall_prev) begin
                check("stall_data", tx_tdata, hold_data);
                check("stall_ctrl", {tx_tvalid, tx_tkeep, tx_tlast}, {1'b1, hold_keep, hold_last});
            end
            if (in_frame) check("no_gap", tx_tvalid, 1);
            if (tx_tvalid && tx_tready) begin
                if (m_idx == 0 && gap_armed) begin
                    check("ipg_len", gap_cnt, m_ipg);
                    last_gap  = gap_cnt;
                    gap_armed = 0;
                end
                rem    = m_len - m_idx;
                e_last = (rem <= 8);
                for (int j = 0; j < 8; j++) begin
                    e_keep[j] = (j < rem);
                    e_mask[8*j +: 8] = (j < rem) ? 8'hFF : 8'h00;
                    if (m_idx + j < 16) e_data[8*j +: 8] = hdr_byte(m_idx + j);
`ifdef ETH_PKT_GEN_PRBS_EN
                    else e_data[8*j +: 8] = prbs_byte();
`else
                    else e_data[8*j +: 8] = 8'(int'(m_seq[7:0]) + m_idx + j - 16);
`endif
                end
                check("tdata", tx_tdata & e_mask, e_data & e_mask);
                check("tkeep", tx_tkeep, e_keep);
                check("tlast", tx_tlast, e_last);
                if (m_idx < 24) cap[m_idx/8] = tx_tdata;
                if (m_idx == 8 && frames < 8) seq_log[frames] = {tx_tdata[55:48], tx_tdata[63:56]};
                beats++;
                m_idx += 8;
                if (e_last) begin
                    m_seq++; frames++; last_beats = beats; beats = 0;
                    last_keep_seen = tx_tkeep; m_idx = 0; gap_cnt = 0; gap_armed = 1; in_frame = 0;
                end else begin
                    in_frame = 1;
                end
            end else if (!tx_tvalid && gap_armed) begin
                gap_cnt++;
            end
            if (done) gap_armed = 0;
            stall_prev = tx_tvalid && !tx_tready;
            hold_data = tx_tdata; hold_keep = tx_tkeep; hold_last = tx_tlast;
        end
    end

    initial begin
        tx_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_start(input int len, input int num, input int ipg, input bit with_stop);
        cfg_pkt_len = 14'(len); cfg_num_pkts = 32'(num); cfg_ipg = 8'(ipg);
        cfg_start = 1'b1; cfg_stop = with_stop;
        m_len = clampl(len); m_ipg = 8'(ipg); m_dst = cfg_dst_mac; m_src = cfg_src_mac;
        m_seq = '0; frames = 0; m_idx = 0; beats = 0; last_gap = -1; prbs_s = '1;
        @(posedge clk); #1;
        cfg_start = 1'b0; cfg_stop = 1'b0;
    endtask

    task automatic pulse_stop();
        cfg_stop = 1'b1;
        @(posedge clk); #1;
        cfg_stop = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!done && n < budget);
        check({name, "_done"}, done, 1);
        check({name, "_busy"}, busy, 0);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
    endtask

    task automatic wait_frames(input int k, input int budget);
        int n = 0;
        while (frames < k && n < budget) begin
            @(negedge clk); n++;
        end
        check("wait_frames", 64'(frames >= k), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", tx_tvalid, 0);
        check("rst_tdata", tx_tdata, 0);
        check("rst_tkeep_tlast", {tx_tkeep, tx_tlast}, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_cnts", {pkt_cnt, byte_cnt[31:0]}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame; literal header/payload words pin the model.
        do_start(64, 1, 0, 0);
        wait_done("t1", 100);
        check("t1_beats", last_beats, 8);
        check("t1_keep", last_keep_seen, 8'hFF);
        check("t1_pkt", pkt_cnt, 1);
        check("t1_bytes", byte_cnt, 64);
        check("t1_hdr0", cap[0], 64'h7766_5544_3322_1100);
        check("t1_hdr1", cap[1], 64'h0000_B588_BBAA_9988);
`ifndef ETH_PKT_GEN_PRBS_EN
        check("t1_pay0", cap[2], 64'h0706_0504_0302_0100);
`endif

        // Odd length and clamps.
        do_start(67, 1, 0, 0);
        wait_done("t2a", 100);
        check("t2a_beats", last_beats, 9);
        check("t2a_keep", last_keep_seen, 8'h07);
        check("t2a_bytes", byte_cnt, 67);
        do_start(10, 1, 0, 0);
        wait_done("t2b", 100);
        check("t2b_beats", last_beats, 8);
        check("t2b_bytes", byte_cnt, 64);
        do_start(12000, 1, 0, 0);
        wait_done("t2c", 1400);
        check("t2c_beats", last_beats, 1200);
        check("t2c_bytes", byte_cnt, 9600);

        // Backpressure.
        bp_en = 1;
        do_start(100, 3, 1, 0);
        wait_done("t3", 1000);
        bp_en = 0;
        check("t3_pkt", pkt_cnt, 3);
        check("t3_bytes", byte_cnt, 300);
        check("t3_keep", last_keep_seen, 8'h0F);
        check("t3_beats", last_beats, 13);
        check("t3_seq", {seq_log[0], seq_log[1], seq_log[2]}, {16'd0, 16'd1, 16'd2});

        // Inter-packet gap.
        do_start(64, 2, 5, 0);
        wait_done("t4a", 200);
        check("t4a_gap", last_gap, 5);
        do_start(64, 2, 0, 0);
        wait_done("t4b", 200);
        check("t4b_gap", last_gap, 0);

        // Continuous run, ignored start while busy, stop during frame index 4.
        do_start(64, 0, 0, 0);
        wait_frames(1, 100);
        cfg_pkt_len = 14'd100; cfg_num_pkts = 32'd1; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        wait_frames(4, 100);
        pulse_stop();
        wait_done("t5a", 100);
        check("t5a_pkt", pkt_cnt, 5);
        check("t5a_bytes", byte_cnt, 320);
        do_start(64, 1, 0, 0);
        @(negedge clk);
        check("t5b_clear", {pkt_cnt, byte_cnt[31:0]}, 0);
        wait_done("t5b", 100);
        check("t5b_pkt", pkt_cnt, 1);
        do_start(64, 0, 20, 0);
        wait_frames(1, 100);
        pulse_stop();
        wait_done("t5c", 1);
        check("t5c_pkt", pkt_cnt, 1);
        pulse_stop();
        @(negedge clk);
        check("t5d_idle_stop", {done, busy}, 0);
        do_start(64, 2, 0, 1);
        wait_done("t5e", 200);
        check("t5e_pkt", pkt_cnt, 2);

        // Asynchronous reset mid-payload.
        do_start(200, 1, 0, 0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", tx_tvalid, 0);
        check("t6_rst_out", {tx_tdata, tx_tkeep, tx_tlast, busy, done}, 0);
        check("t6_rst_cnt", {pkt_cnt, byte_cnt[31:0]}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Sequence wrap: preload seq close to the top on the first header beat.
        do_start(64, 4, 0, 0);
        force dut.seq_q = 16'hFFFE;
        m_seq = 16'hFFFE;
        @(posedge clk); #1;
        release dut.seq_q;
        wait_done("t6w", 200);
        check("t6w_seq", {seq_log[0], seq_log[1], seq_log[2], seq_log[3]},
              {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001});
        check("t6w_pkt", pkt_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
